bootram_seq: RTL and testbench

- Sequencer and arbiter for one 2Kx8 single-port boot RAM bank (Gowin SP primitive, bypass read, 1-cycle read latency).
- Serialises 32-bit CPU bus accesses (valid/ready, byte strobes) into four byte cycles.
- Shares the bank with a byte-wide loader port, used by the UART programmer to write firmware.
- Sits between the CPU bus decoder / loader and the bootram_2kx8 macro.

---
 rtl/bootram_pkg.sv | 19 +
 rtl/bootram_rr_arb.sv | 29 ++
 rtl/bootram_seq.sv | 153 +++++++++++++++
 tb/tb_bootram_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM sequencer and its arbiter.
package bootram_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int RD_LATENCY     = 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CPU_RD  = 3'd1;
  localparam logic [2:0] S_RD_TAIL = 3'd2;
  localparam logic [2:0] S_CPU_WR  = 3'd3;
  localparam logic [2:0] S_LDR_WR  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

endpackage

// File: rtl/bootram_rr_arb.sv
// Two-requester round-robin arbiter (CPU vs loader); rr names who wins a tie.
module bootram_rr_arb
  import bootram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic en,
  output logic cpu_gnt,
  output logic ldr_gnt,
  output logic rr
);

  assign cpu_gnt = cpu_req && (!ldr_req || rr == OWN_CPU);
  assign ldr_gnt = ldr_req && (!cpu_req || rr == OWN_LDR);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr <= OWN_CPU;
    end else if (en && cpu_gnt) begin
      rr <= OWN_LDR;
    end else if (en && ldr_gnt) begin
      rr <= OWN_CPU;
    end
  end

endmodule

// File: rtl/bootram_seq.sv
// Byte sequencer sharing one 2Kx8 boot RAM bank between a 32-bit CPU bus and a
// byte-wide loader. Optional write lock (ROM mode) via `define BOOTRAM_WR_LOCK_EN.
module bootram_seq
  import bootram_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
`ifdef BOOTRAM_WR_LOCK_EN
  input  logic              wr_lock,
`endif
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  input  logic              ldr_valid,
  output logic              ldr_ready,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [7:0]        ldr_wdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [2:0]        state;
  logic [1:0]        idx;
  logic [1:0]        cap_idx;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              lock_q;
  logic              lock_now;
  logic              cpu_gnt;
  logic              ldr_gnt;
  logic              rr;

`ifdef BOOTRAM_WR_LOCK_EN
  assign lock_now = wr_lock;
`else
  assign lock_now = 1'b0;
`endif

  bootram_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .cpu_req (mem_valid),
    .ldr_req (ldr_valid),
    .en      (state == S_IDLE),
    .cpu_gnt (cpu_gnt),
    .ldr_gnt (ldr_gnt),
    .rr      (rr)
  );

  // RAM data lags the address by the read latency, so capture trails idx.
  assign cap_idx = idx - 2'(RD_LATENCY);
  assign ram_oce = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      owner     <= OWN_CPU;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      lock_q    <= 1'b0;
      mem_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idx <= 2'd0;
          if (cpu_gnt) begin
            owner   <= OWN_CPU;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            lock_q  <= lock_now;
            state   <= (mem_wstrb == 4'b0000) ? S_CPU_RD : S_CPU_WR;
          end else if (ldr_gnt) begin
            owner   <= OWN_LDR;
            addr_q  <= ldr_addr;
            wdata_q <= {24'd0, ldr_wdata};
            wstrb_q <= 4'b0001;
            lock_q  <= lock_now;
            state   <= S_LDR_WR;
          end
        end
        S_CPU_RD: begin
          if (idx != 2'd0) mem_rdata[{cap_idx, 3'b000} +: 8] <= ram_dout;
          idx <= idx + 2'd1;
          if (idx == LAST_IDX) state <= S_RD_TAIL;
        end
        S_RD_TAIL: begin
          mem_rdata[31:24] <= ram_dout;
          state            <= S_DONE;
        end
        S_CPU_WR: begin
          idx <= idx + 2'd1;
          if (idx == LAST_IDX) state <= S_DONE;
        end
        S_LDR_WR: state <= S_DONE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and forced idle during reset, so an aborted
  // access performs no further RAM cycle and issues no ready pulse.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    ram_ce    = 1'b0;
    ram_wre   = 1'b0;
    ram_ad    = '0;
    ram_din   = '0;
    mem_ready = 1'b0;
    ldr_ready = 1'b0;
    if (!reset) begin
      case (state)
        S_CPU_RD: begin
          ram_ce = 1'b1;
          ram_ad = {addr_q[ADDR_W-1:2], idx};
        end
        S_CPU_WR: begin
          ram_ce  = 1'b1;
          ram_ad  = {addr_q[ADDR_W-1:2], idx};
          ram_din = wdata_q[{idx, 3'b000} +: 8];
          ram_wre = wstrb_q[idx] && !lock_q;
        end
        S_LDR_WR: begin
          ram_ce  = 1'b1;
          ram_ad  = addr_q;
          ram_din = wdata_q[7:0];
          ram_wre = !lock_q;
        end
        S_DONE: begin
          mem_ready = (owner == OWN_CPU);
          ldr_ready = (owner == OWN_LDR);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bootram_seq.sv
// Directed self-checking bench for bootram_seq with a behavioural 2Kx8 RAM model.
module tb_bootram_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_ram;
`ifdef BOOTRAM_WR_LOCK_EN
  logic        wr_lock;
`endif
  logic        mem_valid;
  logic        mem_ready;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        ldr_valid;
  logic        ldr_ready;
  logic [10:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        ram_ce;
  logic        ram_oce;
  logic        ram_wre;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  ram [0:2047];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bootram_seq #(.ADDR_W(11)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef BOOTRAM_WR_LOCK_EN
    .wr_lock   (wr_lock),
`endif
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .ldr_valid (ldr_valid),
    .ldr_ready (ldr_ready),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ram_ce    (ram_ce),
    .ram_oce   (ram_oce),
    .ram_wre   (ram_wre),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Addresses 0..7 hold their own index; everything else holds addr[7:0]^0x5A.
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 2048; i++)
        ram[i] <= (i < 8) ? 8'(i) : (8'(i) ^ 8'h5A);
    end else if (ram_ce) begin
      if (ram_wre) ram[ram_ad] <= ram_din;
      ram_dout <= ram_wre ? ram_din : ram[ram_ad];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cpu_xfer(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1'b1;
    lat = 0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (mem_ready) begin lat = c; rd = mem_rdata; break; end
    end
    mem_valid = 1'b0;
  endtask

  task automatic ldr_xfer(input logic [10:0] a, input logic [7:0] d,
                          output int lat, output logic saw_wre);
    @(negedge clk);
    ldr_addr = a; ldr_wdata = d; ldr_valid = 1'b1;
    lat = 0; saw_wre = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (ram_wre) saw_wre = 1'b1;
      if (ldr_ready) begin lat = c; break; end
    end
    ldr_valid = 1'b0;
  endtask

  logic [31:0] rd;
  int          lat;
  logic        saw_wre;
  logic [1:0]  seq [4];
  int          n_seq;
  logic        found;
  int          n_rdy;

  initial begin
    reset = 1'b1; init_ram = 1'b1;
`ifdef BOOTRAM_WR_LOCK_EN
    wr_lock = 1'b0;
`endif
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    ldr_valid = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; init_ram = 1'b0;
    #1;
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_ldr_ready", 32'(ldr_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_ram_ce",    32'(ram_ce), 32'd0);
    check("rst_ram_wre",   32'(ram_wre), 32'd0);
    check("rst_ram_ad",    32'(ram_ad), 32'd0);
    check("ram_oce_tied",  32'(ram_oce), 32'd1);

    cpu_xfer(11'h004, 32'h0, 4'b0000, rd, lat);
    check("rd004_data", rd, 32'h07060504);
    check("rd004_lat", 32'(lat), 32'd6);
    @(negedge clk);
    check("rd004_ready_one_cycle", 32'(mem_ready), 32'd0);
    check("rd004_rdata_hold", mem_rdata, 32'h07060504);

    cpu_xfer(11'h010, 32'hAABBCCDD, 4'b0101, rd, lat);
    check("wr010_lat", 32'(lat), 32'd5);
    cpu_xfer(11'h010, 32'h0, 4'b0000, rd, lat);
    check("wr010_readback", rd, 32'h49BB4BDD);

    ldr_xfer(11'h7FF, 8'hA5, lat, saw_wre);
    check("ldr7ff_lat", 32'(lat), 32'd2);
    check("ldr7ff_wre_seen", 32'(saw_wre), 32'd1);
    cpu_xfer(11'h7FC, 32'h0, 4'b0000, rd, lat);
    check("rd7fc_data", rd, 32'hA5A4A7A6);

    // Reset in the middle of a full-word write, while byte 2 is on the bus.
    @(negedge clk);
    mem_addr = 11'h020; mem_wdata = 32'h11223344; mem_wstrb = 4'b1111; mem_valid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (ram_ce && ram_ad == 11'h022) begin found = 1'b1; break; end
    end
    check("midrst_reached_idx2", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; mem_valid = 1'b0;
    #1;
    check("midrst_ram_ce",    32'(ram_ce), 32'd0);
    check("midrst_ram_wre",   32'(ram_wre), 32'd0);
    check("midrst_ram_ad",    32'(ram_ad), 32'd0);
    check("midrst_ram_din",   32'(ram_din), 32'd0);
    check("midrst_mem_rdata", mem_rdata, 32'd0);
    n_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_ready) n_rdy++;
    end
    check("midrst_no_ready", 32'(n_rdy), 32'd0);

    // Both requesters held: CPU first after reset, then strict alternation.
    @(negedge clk);
    mem_addr = 11'h000; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    ldr_addr = 11'h100; ldr_wdata = 8'h77; ldr_valid = 1'b1;
    n_seq = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); @(negedge clk);
      if (mem_ready && n_seq < 4) begin seq[n_seq] = 2'd0; n_seq++; end
      if (ldr_ready && n_seq < 4) begin seq[n_seq] = 2'd1; n_seq++; end
      if (n_seq >= 4) break;
    end
    mem_valid = 1'b0; ldr_valid = 1'b0;
    check("arb_count", 32'(n_seq), 32'd4);
    check("arb_0_cpu", 32'(seq[0]), 32'd0);
    check("arb_1_ldr", 32'(seq[1]), 32'd1);
    check("arb_2_cpu", 32'(seq[2]), 32'd0);
    check("arb_3_ldr", 32'(seq[3]), 32'd1);

    cpu_xfer(11'h020, 32'h0, 4'b0000, rd, lat);
    check("midrst_readback", rd, 32'h79783344);
    cpu_xfer(11'h000, 32'h0, 4'b0000, rd, lat);
    check("rd000_data", rd, 32'h03020100);

`ifdef BOOTRAM_WR_LOCK_EN
    wr_lock = 1'b1;
    ldr_xfer(11'h020, 8'h3C, lat, saw_wre);
    check("lock_ldr_lat", 32'(lat), 32'd2);
    check("lock_no_wre", 32'(saw_wre), 32'd0);
    check("lock_ram_kept", 32'(ram[11'h020]), 32'h44);
    cpu_xfer(11'h020, 32'h0, 4'b0000, rd, lat);
    check("lock_read_ok", rd, 32'h79783344);
    wr_lock = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
